// File: rtl/multu_pkg.sv
// Shared execute-stage definitions: funct codes for the ALU and the
// HI/LO multiplier, the multiplier state type and the default operand width.
package multu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Multiplier / HI-LO funct codes
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    // ALU funct codes, kept here so both execute units share one source
    localparam logic [5:0] AND   = 6'b100100;
    localparam logic [5:0] OR    = 6'b100101;
    localparam logic [5:0] ADD   = 6'b100000;
    localparam logic [5:0] SUB   = 6'b100010;
    localparam logic [5:0] SLT   = 6'b101010;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } multu_state_t;

endpackage

// File: rtl/multu_hilo_if.sv
// Execute-stage request/result bundle between the pipeline (master) and
// the HI/LO multiplier (slave).
interface multu_hilo_if
    import multu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dataOut;

    modport master (
        output dataA, dataB, Signal, start,
        input  busy, done, dataOut
    );

    modport slave (
        input  dataA, dataB, Signal, start,
        output busy, done, dataOut
    );
endinterface

// File: rtl/multu_hilo.sv
// Iterative shift-add unsigned multiplier with architectural HI/LO
// registers. One product bit is resolved per cycle; HI/LO are only
// updated when the full product is ready, so MFHI/MFLO issued during a
// multiply return the previous result.
module multu_hilo
    import multu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    multu_hilo_if.slave  bus
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    multu_state_t       state;
    multu_state_t       next_state;
    logic               busy_q;
    logic               done_q;
    logic               accept;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    assign accept = bus.start && (bus.Signal == MULTU);

    // Next-state decode; start is only looked at while idle
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch)
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (cnt == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register with registered busy/done flags derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            state  <= next_state;
            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);
        end
    end

    // Conditional add of the multiplicand into the upper half, carry kept
    always_comb begin
        sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) sum = sum + {1'b0, mcand};
    end

    // Datapath: operand capture, shift-add iterations, HI/LO commit
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= bus.dataA;
                        prod  <= {{WIDTH{1'b0}}, bus.dataB};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= {sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Readback mux: zero for any funct that is not a HI/LO move
    always_comb begin
        case (bus.Signal)
            MFHI:    bus.dataOut = hi;
            MFLO:    bus.dataOut = lo;
            default: bus.dataOut = '0;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: directed scenarios plus randomized
// operands, compared against a 64-bit arithmetic reference and a
// cycle-count model of the request/done protocol.
module tb_multu_hilo;
    import multu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multu_hilo_if bus ();

    multu_hilo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference view of the architectural HI/LO registers
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [5:0] f, output logic [31:0] v);
        bus.Signal = f;
        #1;
        v = bus.dataOut;
    endtask

    // Issue one MULTU and follow it until busy drops (bounded)
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int busy_cycles, output int done_cycles,
                            output int done_at);
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        busy_cycles = 0;
        done_cycles = 0;
        done_at     = -1;
        while (bus.busy && busy_cycles < 40) begin
            if (bus.done) begin
                done_cycles++;
                done_at = busy_cycles;
            end
            busy_cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = '0;
        bus.start  = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        read_reg(MFHI, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mfhi: got %h expected 0", v); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_mflo: got %h expected 0", v); end
        model_hi = '0;
        model_lo = '0;
    endtask

    task automatic test_small();
        int bc, dc, da;
        logic [31:0] v;
        logic [63:0] exp;
        exp = 64'(32'd3) * 64'(32'd5);
        run_mult(32'd3, 32'd5, bc, dc, da);
        tests++; if (bc != 33) begin fails++; $display("FAIL small_busy_cycles: got %0d expected 33", bc); end
        tests++; if (dc != 1) begin fails++; $display("FAIL small_done_count: got %0d expected 1", dc); end
        tests++; if (da != 32) begin fails++; $display("FAIL small_done_position: got %0d expected 32", da); end
        read_reg(MFHI, v);
        tests++; if (v !== exp[63:32]) begin fails++; $display("FAIL small_hi: got %h expected %h", v, exp[63:32]); end
        read_reg(MFLO, v);
        tests++; if (v !== exp[31:0]) begin fails++; $display("FAIL small_lo: got %h expected %h", v, exp[31:0]); end
        read_reg(MULTU, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL small_other_funct: got %h expected 0", v); end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic test_max();
        int bc, dc, da;
        logic [31:0] v;
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, da);
        read_reg(MFHI, v);
        tests++; if (v !== 32'hFFFF_FFFE) begin fails++; $display("FAIL max_hi: got %h expected fffffffe", v); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'h0000_0001) begin fails++; $display("FAIL max_lo: got %h expected 00000001", v); end
        model_hi = 32'hFFFF_FFFE;
        model_lo = 32'h0000_0001;
    endtask

    task automatic test_back_to_back();
        int bc, dc, da;
        logic [31:0] v;
        run_mult(32'h1234_5678, 32'h0, bc, dc, da);
        read_reg(MFHI, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL b2b_first_hi: got %h expected 0", v); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL b2b_first_lo: got %h expected 0", v); end
        // Still in the cycle right after DONE: this start must be taken
        run_mult(32'h0, 32'h9ABC_DEF0, bc, dc, da);
        tests++; if (bc != 33) begin fails++; $display("FAIL b2b_second_busy_cycles: got %0d expected 33", bc); end
        tests++; if (dc != 1) begin fails++; $display("FAIL b2b_second_done_count: got %0d expected 1", dc); end
        read_reg(MFHI, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL b2b_second_hi: got %h expected 0", v); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL b2b_second_lo: got %h expected 0", v); end
        model_hi = '0;
        model_lo = '0;
    endtask

    task automatic test_random();
        int bc, dc, da;
        logic [31:0] a, b, v;
        logic [63:0] exp;
        logic [5:0] f;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'h8000_0001;
            if (i == 1) b = 32'hFFFF_FFFF;
            exp = 64'(a) * 64'(b);
            run_mult(a, b, bc, dc, da);
            tests++; if (dc != 1) begin fails++; $display("FAIL rand%0d_done_count: got %0d expected 1", i, dc); end
            read_reg(MFHI, v);
            tests++; if (v !== exp[63:32]) begin fails++; $display("FAIL rand%0d_hi (%h*%h): got %h expected %h", i, a, b, v, exp[63:32]); end
            read_reg(MFLO, v);
            tests++; if (v !== exp[31:0]) begin fails++; $display("FAIL rand%0d_lo (%h*%h): got %h expected %h", i, a, b, v, exp[31:0]); end
            model_hi = exp[63:32];
            model_lo = exp[31:0];
            f = 6'($urandom_range(0, 63));
            if (f == MFHI || f == MFLO) f = ADD;
            read_reg(f, v);
            tests++; if (v !== 32'h0) begin fails++; $display("FAIL rand%0d_funct_%0d: got %h expected 0", i, f, v); end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] v;
        logic [31:0] prev_lo;
        prev_lo = model_lo;
        bus.dataA  = 32'd7;
        bus.dataB  = 32'd6;
        bus.Signal = MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        for (int k = 1; k <= 32; k++) begin
            if (k == 10) begin
                bus.start  = 1'b1;
                bus.Signal = MULTU;
                bus.dataA  = 32'd2;
                bus.dataB  = 32'd2;
            end
            if (k == 11) begin
                bus.start  = 1'b0;
                bus.Signal = 6'd0;
            end
            if (k == 20) begin
                read_reg(MFLO, v);
                tests++; if (v !== prev_lo) begin fails++; $display("FAIL run_mflo_stale: got %h expected %h", v, prev_lo); end
                bus.Signal = 6'd0;
            end
            tick();
        end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL ign_done_pulse: got %b expected 1", bus.done); end
        tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ign_busy_after: got %b expected 0", bus.busy); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'd42) begin fails++; $display("FAIL ign_lo: got %0d expected 42", v); end
        read_reg(MFHI, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL ign_hi: got %0d expected 0", v); end
        tick();
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ign_no_restart: got %b expected 0", bus.busy); end
        model_hi = '0;
        model_lo = 32'd42;
    endtask

    task automatic test_reset_abort();
        int bc, dc, da;
        int late_done, late_busy;
        logic [31:0] v;
        bus.dataA  = 32'hFFFF_0000;
        bus.dataB  = 32'h0001_0000;
        bus.Signal = MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b expected 0", bus.done); end
        read_reg(MFHI, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL abort_hi: got %h expected 0", v); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'h0) begin fails++; $display("FAIL abort_lo: got %h expected 0", v); end
        bus.Signal = 6'd0;
        late_done = 0;
        late_busy = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done) late_done++;
            if (bus.busy) late_busy++;
        end
        tests++; if (late_done != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", late_done); end
        tests++; if (late_busy != 0) begin fails++; $display("FAIL abort_no_busy: got %0d cycles expected 0", late_busy); end
        model_hi = '0;
        model_lo = '0;
        run_mult(32'd2, 32'd3, bc, dc, da);
        tests++; if (bc != 33) begin fails++; $display("FAIL fresh_busy_cycles: got %0d expected 33", bc); end
        read_reg(MFLO, v);
        tests++; if (v !== 32'd6) begin fails++; $display("FAIL fresh_lo: got %0d expected 6", v); end
        read_reg(MFHI, v);
        tests++; if (v !== 32'd0) begin fails++; $display("FAIL fresh_hi: got %0d expected 0", v); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_small();
        test_max();
        test_back_to_back();
        test_random();
        test_ignored_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32×32 unsigned multiplier with architectural HI/LO registers, sitting in the execute stage beside the combinational ALU. It takes the same operand buses and 6-bit funct `Signal` as the ALU. Its `dataOut` feeds the same execute-stage result select that the ALU result feeds. It implements MULTU using iterative shift-add, plus MFHI and MFLO readback.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the product is 2×WIDTH.

Ports:
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  synchronous, active-high reset.
- `dataA`  input  32  multiplicand.
- `dataB`  input  32  multiplier.
- `Signal`  input  6  funct code: MULTU=6'b011001 (25), MFHI=6'b010000 (16), MFLO=6'b010010 (18); all other codes are ignored.
- `start`  input  1  qualifies a MULTU request for one cycle.
- `busy`  output  1  high while a multiply is in progress.
- `done`  output  1  single-cycle pulse when HI/LO take a new product.
- `dataOut`  output  32  HI when `Signal`=MFHI, LO when `Signal`=MFLO, otherwise 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start` && `Signal`==MULTU.
  - At that edge: `mcand`←`dataA`, `prod`←{32'b0, `dataB`}, `cnt`←0.
- RUN, one iteration per cycle:
  - If `prod[0]`, then `sum[32:0]` = `prod[63:32]` + `mcand` (33-bit, carry kept); otherwise `sum` = {1'b0, `prod[63:32]`}.
  - `prod` ← {`sum`, `prod[31:1]`}.
  - `cnt`++.
  - After the iteration with `cnt`==31, go to DONE.
- DONE:
  - HI←`prod[63:32]`, LO←`prod[31:0]`, `done`=1 for this cycle only.
  - Next state is IDLE.
- `start` is ignored in RUN and DONE. A dropped request is not queued.
- `start` with `Signal`≠MULTU is ignored.
- HI/LO change only in DONE and on reset. The internal `prod` register is never visible on `dataOut`.
- `dataOut` is combinational from `Signal` and the HI/LO registers.
  - During RUN it returns the previous HI/LO. There is no stall or forwarding.
- The result is exact: all unsigned 64-bit products are representable, so there is no overflow.
- Reset values: state IDLE, `busy`=0, `done`=0, HI=0, LO=0, `cnt`=0, `prod`=0, `mcand`=0. As a result, `dataOut` is 0 for any `Signal`.
- Reset in RUN or DONE aborts the multiply. HI and LO read 0 afterwards, not the partial or old value.
- Reset has priority over `start` in the same cycle.

## Timing
- Edge numbering:
  - Edge 0 accepts `start`.
  - Edges 1..32 perform the iterations.
  - At edge 33 the state is DONE: `done`=1 in the cycle after edge 32, and HI/LO are written at edge 33.
- HI/LO are visible on `dataOut` in the cycle after edge 33.
- `busy` is high from the cycle after edge 0 through the DONE cycle (33 cycles).
- Back-to-back multiplies: the earliest next accepted `start` is the cycle after DONE. This gives 34 cycles per multiply.
- `done` and `busy` are registered outputs. `dataOut` has zero latency relative to `Signal`.

## Structure
- Shared package `multu_pkg`:
  - funct localparams `MULTU`, `MFHI`, `MFLO`.
  - State enum `multu_state_t` {IDLE, RUN, DONE}.
  - `WIDTH` default.
- The ALU's funct constants (AND/OR/ADD/SUB/SLT) move into the same package, so both execute units share one source.
- Single module, no sub-module.
  - The 33-bit add is inline.
  - The 5-bit iteration counter is inline.
  - The FSM is one `always` block and the datapath registers are a second.

## Test plan
- 3 × 5 with `start` pulsed once: `busy` is high for 33 cycles, then a single `done`. Then MFHI → 0x00000000 and MFLO → 0x0000000F.
- 0xFFFFFFFF × 0xFFFFFFFF: MFHI → 0xFFFFFFFE, MFLO → 0x00000001. This checks that the 33-bit carry is kept every iteration.
- 0x12345678 × 0 followed by 0 × 0x9ABCDEF0: both give HI=LO=0.
  - Issue the second `start` in the cycle after DONE. It must be accepted, with `busy` rising the next cycle.
- During a 7×6 multiply:
  - Pulse `start` with 2×2 at iteration 10. It is ignored, and the final LO is 42 (not 4).
  - Drive MFLO at iteration 20. `dataOut` shows the previous LO.
- Assert `reset` for one cycle at iteration 16 of 0xFFFF0000 × 0x10000:
  - Next cycle: state IDLE, `busy`=0, `done`=0, MFHI and MFLO both read 0.
  - No `done` pulse follows.
  - A fresh 2×3 multiply then returns LO=6.
